// File: rtl/lock_search_ctrl.sv
// Sequencer for the PCMA lock calculator: latches a histogram frame, finds its
// argmax bin, hands both to the calculator and applies lock/unlock hysteresis.
module lock_search_ctrl #(
   parameter int DATA_WIDTH      = 16,
   parameter int BOUND_NUM       = 32,
   parameter int BOUND_NUM_WIDTH = 5,
   parameter int LOCK_THR        = 3,
   parameter int UNLOCK_THR      = 2,
   parameter int SEARCH_TRIES    = 4,
   parameter int WAIT_TIMEOUT    = 64
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            enable_i,
   input  logic                            hist_val_i,
   input  logic [DATA_WIDTH*BOUND_NUM-1:0] hist_data_i,
   output logic                            hist_rdy_o,
   output logic                            calc_val_o,
   output logic [DATA_WIDTH*BOUND_NUM-1:0] calc_data_o,
   output logic [BOUND_NUM_WIDTH-1:0]      calc_max_num_o,
   output logic [2:0]                      calc_mode_o,
   input  logic                            calc_val_i,
   input  logic                            calc_lock_i,
   output logic [2:0]                      mode_o,
   output logic                            locked_o,
   output logic                            status_val_o,
   output logic                            timeout_o
);

   localparam int HIT_W  = $clog2(LOCK_THR + 1);
   localparam int MISS_W = $clog2(UNLOCK_THR + 1);
   localparam int TRY_W  = $clog2(SEARCH_TRIES + 1);
   localparam int TMR_W  = $clog2(WAIT_TIMEOUT + 1);

   localparam logic [HIT_W-1:0]           HIT_LAST  = HIT_W'(LOCK_THR - 1);
   localparam logic [MISS_W-1:0]          MISS_LAST = MISS_W'(UNLOCK_THR - 1);
   localparam logic [TRY_W-1:0]           TRY_LAST  = TRY_W'(SEARCH_TRIES - 1);
   localparam logic [TMR_W-1:0]           TMR_LAST  = TMR_W'(WAIT_TIMEOUT - 1);
   localparam logic [BOUND_NUM_WIDTH-1:0] SCAN_LAST = BOUND_NUM_WIDTH'(BOUND_NUM - 1);

   localparam logic [2:0] MODE_FM4 = 3'b001;
   localparam logic [2:0] MODE_FM8 = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_ISSUE,
      S_WAIT,
      S_UPDATE
   } state_t;

   state_t                           r_state;
   state_t                           w_next_state;
   logic [DATA_WIDTH*BOUND_NUM-1:0]  r_frame;
   logic [DATA_WIDTH-1:0]            r_max_val;
   logic [BOUND_NUM_WIDTH-1:0]       r_max_idx;
   logic [BOUND_NUM_WIDTH-1:0]       r_scan_idx;
   logic [TMR_W-1:0]                 r_timer;
   logic                             r_verdict;
   logic                             r_timeout;
   logic [HIT_W-1:0]                 r_hit_cnt;
   logic [MISS_W-1:0]                r_miss_cnt;
   logic [TRY_W-1:0]                 r_try_cnt;
   logic                             r_locked;
   logic [2:0]                       r_mode;
   logic [DATA_WIDTH-1:0]            w_bins [BOUND_NUM];
   logic [DATA_WIDTH-1:0]            w_cur_bin;

   always_comb begin
      for (int i = 0; i < BOUND_NUM; i++) begin
         w_bins[i] = r_frame[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign w_cur_bin = w_bins[r_scan_idx];

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; a low enable wins over every state
   always_comb begin
      w_next_state = r_state;
      if (!enable_i) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:   if (hist_val_i) w_next_state = S_SCAN;
            S_SCAN:   if (r_scan_idx == SCAN_LAST) w_next_state = S_ISSUE;
            S_ISSUE:  w_next_state = S_WAIT;
            S_WAIT:   if (calc_val_i || (r_timer == TMR_LAST)) w_next_state = S_UPDATE;
            S_UPDATE: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
         endcase
      end
   end

   // Output decode; ready is gated by reset so it reads 0 while reset is held
   always_comb begin
      hist_rdy_o   = 1'b0;
      calc_val_o   = 1'b0;
      status_val_o = 1'b0;
      timeout_o    = 1'b0;
      case (r_state)
         S_IDLE:   hist_rdy_o = enable_i && reset_n;
         S_ISSUE:  calc_val_o = 1'b1;
         S_UPDATE: begin
            status_val_o = 1'b1;
            timeout_o    = r_timeout;
         end
         default: ;
      endcase
   end

   assign calc_data_o    = r_frame;
   assign calc_max_num_o = r_max_idx;
   assign calc_mode_o    = r_mode;
   assign mode_o         = r_mode;
   assign locked_o       = r_locked;

   // Frame capture, argmax scan, verdict capture and hysteresis counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame    <= '0;
         r_max_val  <= '0;
         r_max_idx  <= '0;
         r_scan_idx <= '0;
         r_timer    <= '0;
         r_verdict  <= 1'b0;
         r_timeout  <= 1'b0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         r_try_cnt  <= '0;
         r_locked   <= 1'b0;
         r_mode     <= MODE_FM4;
      end else if (!enable_i) begin
         r_scan_idx <= '0;
         r_timer    <= '0;
         r_timeout  <= 1'b0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         r_try_cnt  <= '0;
         r_locked   <= 1'b0;
         r_mode     <= MODE_FM4;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (hist_val_i) begin
                  r_frame    <= hist_data_i;
                  r_max_val  <= '0;
                  r_max_idx  <= '0;
                  r_scan_idx <= '0;
               end
            end
            S_SCAN: begin
               // Strict compare keeps the lowest index on ties
               if (w_cur_bin > r_max_val) begin
                  r_max_val <= w_cur_bin;
                  r_max_idx <= r_scan_idx;
               end
               r_scan_idx <= (r_scan_idx == SCAN_LAST) ? '0 : r_scan_idx + 1'b1;
            end
            S_ISSUE: begin
               r_timer   <= '0;
               r_timeout <= 1'b0;
            end
            S_WAIT: begin
               if (calc_val_i) begin
                  r_verdict <= calc_lock_i;
               end else if (r_timer == TMR_LAST) begin
                  r_verdict <= 1'b0;
                  r_timeout <= 1'b1;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_UPDATE: begin
               if (!r_locked) begin
                  if (r_verdict) begin
                     if (r_hit_cnt == HIT_LAST) begin
                        r_locked   <= 1'b1;
                        r_hit_cnt  <= '0;
                        r_miss_cnt <= '0;
                        r_try_cnt  <= '0;
                     end else begin
                        r_hit_cnt <= r_hit_cnt + 1'b1;
                     end
                  end else begin
                     r_hit_cnt <= '0;
                     if (r_try_cnt == TRY_LAST) begin
                        r_mode    <= (r_mode == MODE_FM4) ? MODE_FM8 : MODE_FM4;
                        r_try_cnt <= '0;
                     end else begin
                        r_try_cnt <= r_try_cnt + 1'b1;
                     end
                  end
               end else begin
                  if (r_verdict) begin
                     r_miss_cnt <= '0;
                  end else if (r_miss_cnt == MISS_LAST) begin
                     r_locked   <= 1'b0;
                     r_hit_cnt  <= '0;
                     r_miss_cnt <= '0;
                     r_try_cnt  <= '0;
                  end else begin
                     r_miss_cnt <= r_miss_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lock_search_ctrl.sv
// Bench for lock_search_ctrl: directed table of verdict sequences, hand-written
// disable/reset/timeout corners, then randomized frames against a rule model.
module tb_lock_search_ctrl;

   localparam int DW = 16;
   localparam int BN = 32;
   localparam int BW = 5;
   localparam int LT = 3;
   localparam int UT = 2;
   localparam int ST = 4;
   localparam int WT = 16;
   localparam int FW = DW * BN;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          enable_i;
   logic          hist_val_i;
   logic [FW-1:0] hist_data_i;
   logic          hist_rdy_o;
   logic          calc_val_o;
   logic [FW-1:0] calc_data_o;
   logic [BW-1:0] calc_max_num_o;
   logic [2:0]    calc_mode_o;
   logic          calc_val_i;
   logic          calc_lock_i;
   logic [2:0]    mode_o;
   logic          locked_o;
   logic          status_val_o;
   logic          timeout_o;

   always #5 clk = ~clk;

   lock_search_ctrl #(
      .DATA_WIDTH(DW), .BOUND_NUM(BN), .BOUND_NUM_WIDTH(BW), .LOCK_THR(LT),
      .UNLOCK_THR(UT), .SEARCH_TRIES(ST), .WAIT_TIMEOUT(WT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable_i(enable_i),
      .hist_val_i(hist_val_i), .hist_data_i(hist_data_i), .hist_rdy_o(hist_rdy_o),
      .calc_val_o(calc_val_o), .calc_data_o(calc_data_o),
      .calc_max_num_o(calc_max_num_o), .calc_mode_o(calc_mode_o),
      .calc_val_i(calc_val_i), .calc_lock_i(calc_lock_i), .mode_o(mode_o),
      .locked_o(locked_o), .status_val_o(status_val_o), .timeout_o(timeout_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_wide(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Behavioural reference: counters as plain integers, rules as stated
   int         m_hit, m_miss, m_try;
   logic       m_locked;
   logic [2:0] m_mode;

   task automatic model_reset();
      m_hit = 0; m_miss = 0; m_try = 0; m_locked = 1'b0; m_mode = 3'b001;
   endtask

   task automatic model_update(input logic hit);
      if (!m_locked) begin
         if (hit) begin
            m_hit++;
            if (m_hit >= LT) begin
               m_locked = 1'b1; m_hit = 0; m_miss = 0; m_try = 0;
            end
         end else begin
            m_hit = 0;
            m_try++;
            if (m_try >= ST) begin
               m_mode = (m_mode == 3'b001) ? 3'b010 : 3'b001;
               m_try  = 0;
            end
         end
      end else if (hit) begin
         m_miss = 0;
      end else begin
         m_miss++;
         if (m_miss >= UT) begin
            m_locked = 1'b0; m_hit = 0; m_miss = 0; m_try = 0;
         end
      end
   endtask

   function automatic int model_argmax(input logic [FW-1:0] f);
      int mx = 0;
      for (int i = 0; i < BN; i++) if (int'(f[i*DW +: DW]) > mx) mx = int'(f[i*DW +: DW]);
      for (int i = 0; i < BN; i++) if (int'(f[i*DW +: DW]) == mx) return i;
      return 0;
   endfunction

   function automatic logic [FW-1:0] rand_frame();
      logic [FW-1:0] f;
      int kind = $urandom_range(0, 3);
      for (int i = 0; i < BN; i++) begin
         if (kind == 0)      f[i*DW +: DW] = '0;
         else if (kind == 1) f[i*DW +: DW] = DW'($urandom_range(0, 3));
         else                f[i*DW +: DW] = DW'($urandom);
      end
      return f;
   endfunction

   task automatic check_reset_outputs(input string p);
      chk({p, "_rdy"}, hist_rdy_o, 0);
      chk({p, "_calc_val"}, calc_val_o, 0);
      chk_wide({p, "_calc_data"}, calc_data_o, '0);
      chk({p, "_max_num"}, calc_max_num_o, 0);
      chk({p, "_calc_mode"}, calc_mode_o, 3'b001);
      chk({p, "_mode"}, mode_o, 3'b001);
      chk({p, "_locked"}, locked_o, 0);
      chk({p, "_status"}, status_val_o, 0);
      chk({p, "_timeout"}, timeout_o, 0);
   endtask

   // One full frame transaction, entered and left on a falling edge
   task automatic run_frame(input logic [FW-1:0] frame, input logic verdict, input logic tmo,
                            input int dly, input logic late, input logic [2:0] cur_mode,
                            input logic exp_locked, input logic [2:0] exp_mode);
      int n;
      int cnt;
      logic rdy_seen;
      int exp_idx;
      exp_idx = model_argmax(frame);
      chk("rdy_idle", hist_rdy_o, 1);
      hist_val_i = 1'b1; hist_data_i = frame;
      @(posedge clk);
      @(negedge clk);
      hist_val_i = 1'b0; hist_data_i = ~frame;
      n = 1; rdy_seen = 1'b0;
      while (!calc_val_o && n < 60) begin
         if (hist_rdy_o) rdy_seen = 1'b1;
         @(negedge clk);
         n++;
      end
      chk("issue_cycle", n, BN + 1);
      chk("rdy_low_busy", rdy_seen, 0);
      chk("max_idx", calc_max_num_o, exp_idx);
      chk("calc_mode_issue", calc_mode_o, cur_mode);
      chk_wide("calc_data", calc_data_o, frame);
      @(negedge clk);
      chk("calc_val_one_cycle", calc_val_o, 0);
      chk("max_idx_wait", calc_max_num_o, exp_idx);
      if (!tmo) begin
         repeat (dly) @(negedge clk);
         calc_val_i = 1'b1; calc_lock_i = verdict;
         @(negedge clk);
         calc_val_i = 1'b0; calc_lock_i = 1'($urandom);
         chk("status_pulse", status_val_o, 1);
         chk("no_timeout", timeout_o, 0);
      end else begin
         n = 1;
         while (!status_val_o && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("timeout_cycle", n, WT + 1);
         chk("timeout_pulse", timeout_o, 1);
      end
      @(negedge clk);
      chk("locked", locked_o, exp_locked);
      chk("mode", mode_o, exp_mode);
      chk("calc_mode_follow", calc_mode_o, exp_mode);
      chk("status_done", status_val_o, 0);
      chk("rdy_back", hist_rdy_o, 1);
      if (tmo && late) begin
         @(negedge clk);
         @(negedge clk);
         calc_val_i = 1'b1; calc_lock_i = 1'b1;
         @(negedge clk);
         calc_val_i = 1'b0;
         cnt = 0;
         repeat (3) begin
            if (status_val_o) cnt++;
            @(negedge clk);
         end
         chk("late_verdict_ignored", cnt, 0);
         chk("late_locked", locked_o, exp_locked);
      end
   endtask

   task automatic model_frame(input logic [FW-1:0] f, input logic v, input logic tmo,
                              input int dly, input logic late);
      logic [2:0] cm;
      cm = m_mode;
      model_update(tmo ? 1'b0 : v);
      run_frame(f, v, tmo, dly, late, cm, m_locked, m_mode);
   endtask

   typedef struct {
      logic       verdict;
      logic       tmo;
      logic       late;
      logic       exp_locked;
      logic [2:0] exp_mode;
   } vec_t;

   vec_t vecs [23];

   task automatic setv(input int i, input logic v, input logic t, input logic l,
                       input logic el, input logic [2:0] em);
      vecs[i].verdict = v; vecs[i].tmo = t; vecs[i].late = l;
      vecs[i].exp_locked = el; vecs[i].exp_mode = em;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [FW-1:0] f;
      logic [2:0]    prev;
      int            n;
      int            cnt;

      // acquisition, unlock, two mode toggles, hit-count clear, timeouts
      setv(0, 1, 0, 0, 0, 3'b001);  setv(1, 1, 0, 0, 0, 3'b001);
      setv(2, 1, 0, 0, 1, 3'b001);  setv(3, 0, 0, 0, 1, 3'b001);
      setv(4, 1, 0, 0, 1, 3'b001);  setv(5, 0, 0, 0, 1, 3'b001);
      setv(6, 0, 0, 0, 0, 3'b001);  setv(7, 0, 0, 0, 0, 3'b001);
      setv(8, 0, 0, 0, 0, 3'b001);  setv(9, 0, 0, 0, 0, 3'b001);
      setv(10, 0, 0, 0, 0, 3'b010); setv(11, 0, 0, 0, 0, 3'b010);
      setv(12, 0, 0, 0, 0, 3'b010); setv(13, 0, 0, 0, 0, 3'b010);
      setv(14, 0, 0, 0, 0, 3'b001); setv(15, 1, 0, 0, 0, 3'b001);
      setv(16, 1, 0, 0, 0, 3'b001); setv(17, 0, 0, 0, 0, 3'b001);
      setv(18, 1, 0, 0, 0, 3'b001); setv(19, 1, 0, 0, 0, 3'b001);
      setv(20, 1, 0, 0, 1, 3'b001); setv(21, 0, 1, 1, 1, 3'b001);
      setv(22, 0, 1, 0, 0, 3'b001);

      reset_n = 1'b0; enable_i = 1'b0; hist_val_i = 1'b0; hist_data_i = '0;
      calc_val_i = 1'b0; calc_lock_i = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_outputs("rst");
      reset_n = 1'b1; enable_i = 1'b1;
      @(negedge clk);

      // argmax with a tie between bins 7 and 20
      for (int i = 0; i < BN; i++) f[i*DW +: DW] = 16'd5;
      f[7*DW +: DW]  = 16'd100;
      f[20*DW +: DW] = 16'd100;
      chk("argmax_tie_ref", model_argmax(f), 7);
      model_frame(f, 1'b1, 1'b0, 3, 1'b0);

      enable_i = 1'b0;
      @(negedge clk);
      chk("dis_idle_rdy", hist_rdy_o, 0);
      enable_i = 1'b1;
      model_reset();
      @(negedge clk);

      prev = 3'b001;
      for (int i = 0; i < 23; i++) begin
         run_frame(rand_frame(), vecs[i].verdict, vecs[i].tmo, 2, vecs[i].late, prev,
                   vecs[i].exp_locked, vecs[i].exp_mode);
         prev = vecs[i].exp_mode;
      end
      model_reset();

      // reach fm8 and lock, then drop enable while waiting for a verdict
      repeat (4) model_frame(rand_frame(), 1'b0, 1'b0, 1, 1'b0);
      repeat (3) model_frame(rand_frame(), 1'b1, 1'b0, 1, 1'b0);
      hist_val_i = 1'b1; hist_data_i = rand_frame();
      @(posedge clk);
      @(negedge clk);
      hist_val_i = 1'b0;
      n = 0;
      while (!calc_val_o && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("dis_issue_seen", calc_val_o, 1);
      repeat (3) @(negedge clk);
      enable_i = 1'b0;
      @(negedge clk);
      chk("dis_locked", locked_o, 0);
      chk("dis_mode", mode_o, 3'b001);
      chk("dis_calc_mode", calc_mode_o, 3'b001);
      chk("dis_rdy", hist_rdy_o, 0);
      chk("dis_status", status_val_o, 0);
      enable_i = 1'b1;
      model_reset();
      @(negedge clk);
      chk("dis_rdy_back", hist_rdy_o, 1);
      calc_val_i = 1'b1; calc_lock_i = 1'b1;
      @(negedge clk);
      calc_val_i = 1'b0;
      cnt = 0;
      repeat (3) begin
         if (status_val_o) cnt++;
         @(negedge clk);
      end
      chk("dis_late_ignored", cnt, 0);

      // asynchronous reset in the middle of a scan
      hist_val_i = 1'b1; hist_data_i = rand_frame();
      @(posedge clk);
      @(negedge clk);
      hist_val_i = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("scan_rst");
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      @(negedge clk);
      chk("scan_rst_rdy", hist_rdy_o, 1);

      for (int i = 0; i < 40; i++) begin
         logic v, t, l;
         v = ($urandom_range(0, 9) < 6);
         t = ($urandom_range(0, 7) == 0);
         l = t && ($urandom_range(0, 1) == 1);
         model_frame(rand_frame(), v, t, $urandom_range(0, 12), l);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lock_search_ctrl.md
Name: lock_search_ctrl

Overview:
- Sequencer for the PCMA lock calculator.
- Accepts one histogram frame at a time and finds the maximum bin by sequential argmax.
- Issues the frame, max index and current mode to the lock calculator, then waits for its verdict.
- Applies lock/unlock hysteresis and alternates fm4/fm8 modes while searching; feeds the detector's status outputs.

Parameters:
DATA_WIDTH, 16, width of one histogram bin
BOUND_NUM, 32, number of bins per frame
BOUND_NUM_WIDTH, 5, width of a bin index
LOCK_THR, 3, consecutive lock verdicts required to declare lock
UNLOCK_THR, 2, consecutive miss verdicts required to declare unlock
SEARCH_TRIES, 4, miss verdicts in one mode before switching mode while searching
WAIT_TIMEOUT, 64, cycles to wait for calculator verdict

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable_i  in  1  block enable; low forces idle and clears state
hist_val_i  in  1  histogram frame valid
hist_data_i  in  DATA_WIDTH*BOUND_NUM  frame; bin i at [i*DATA_WIDTH +: DATA_WIDTH]
hist_rdy_o  out  1  frame can be accepted
calc_val_o  out  1  one-cycle start pulse to calculator
calc_data_o  out  DATA_WIDTH*BOUND_NUM  latched frame
calc_max_num_o  out  BOUND_NUM_WIDTH  argmax bin index
calc_mode_o  out  3  mode for calculator (001 fm4, 010 fm8)
calc_val_i  in  1  calculator verdict valid
calc_lock_i  in  1  calculator verdict
mode_o  out  3  current search/lock mode
locked_o  out  1  hysteresis lock status
status_val_o  out  1  one-cycle pulse per processed frame
timeout_o  out  1  one-cycle pulse on verdict timeout

Behaviour:
- Clock/reset: one clock, clk. reset_n is asynchronous, active-low.
- Reset values: all outputs 0, except mode_o = calc_mode_o = 3'b001. Counters and frame register are 0. FSM is in IDLE.
- FSM states: IDLE, SCAN, ISSUE, WAIT, UPDATE.
- IDLE:
  - hist_rdy_o = enable_i.
  - If hist_val_i && hist_rdy_o at edge T0: latch hist_data_i into calc_data_o and go to SCAN.
  - hist_val_i while not ready is dropped; no backpressure storage.
- SCAN:
  - Exactly BOUND_NUM cycles, comparing one bin per cycle, indices 0..BOUND_NUM-1.
  - Strict greater-than update, so on ties the lowest index wins. All-zero frame gives index 0.
  - Running max register is DATA_WIDTH wide, unsigned.
- ISSUE:
  - calc_val_o = 1 for one cycle, in the (BOUND_NUM+1)th cycle after T0.
  - calc_max_num_o and calc_mode_o are valid and stable from ISSUE until leaving WAIT.
  - Go to WAIT.
- WAIT:
  - On calc_val_i: capture calc_lock_i as verdict and go to UPDATE.
  - Otherwise a timer counts; after WAIT_TIMEOUT cycles without calc_val_i, pulse timeout_o, take verdict = miss, go to UPDATE.
  - calc_val_i in any state other than WAIT is ignored.
- UPDATE (one cycle):
  - Pulse status_val_o and apply hysteresis (below).
  - Go to IDLE; hist_rdy_o returns the next cycle.
- Hysteresis while searching (locked_o = 0):
  - hit: hit_cnt++; when hit_cnt reaches LOCK_THR, locked_o <= 1 and all counters are cleared.
  - miss: hit_cnt <= 0, try_cnt++; when try_cnt reaches SEARCH_TRIES, mode_o toggles 001<->010 and try_cnt <= 0.
- Hysteresis while locked (locked_o = 1):
  - hit: miss_cnt <= 0.
  - miss: miss_cnt++; when miss_cnt reaches UNLOCK_THR, locked_o <= 0 and counters are cleared.
  - Mode is held while locked; search resumes in the current mode.
- Output updates: mode_o and locked_o change only in UPDATE. calc_mode_o follows mode_o.
- enable_i low:
  - At the next edge, from any state, go to IDLE and clear counters, locked_o, status pulses and timer.
  - mode_o returns to 001.
  - A frame in flight is discarded; its late calc_val_i is ignored.
- reset_n asserted mid-operation: immediate return to reset values.
- Counter widths: sized with $clog2(threshold+1). No wrap is possible, since each counter clears at its threshold.

Test Plan:
(Parameters BOUND_NUM=32, LOCK_THR=3, UNLOCK_THR=2, SEARCH_TRIES=4, WAIT_TIMEOUT=16.)
- Argmax: all bins 5, bins 7 and 20 = 100, accepted at T0 -> calc_val_o high only in cycle T0+33, calc_max_num_o = 7, calc_data_o equals the frame, hist_rdy_o low until after UPDATE.
- Acquisition: three frames with calc_lock_i = 1 -> locked_o rises in the cycle after the 3rd UPDATE, status_val_o pulses 3 times, mode_o stays 001.
- Mode search: 4 misses -> mode_o = 010 after the 4th UPDATE and calc_mode_o = 010 on the next ISSUE. 4 further misses -> mode_o = 001. Sequence hit, hit, miss -> hit_cnt cleared, locked_o stays 0.
- Unlock: locked, then verdicts miss, hit, miss, miss -> locked_o falls only after the 4th frame. Mode unchanged.
- Timeout: no calc_val_i for 16 cycles after ISSUE -> timeout_o pulse, counted as a miss, return to IDLE. calc_val_i arriving 3 cycles later is ignored (no status_val_o).
- Disable/reset: enable_i low during WAIT -> IDLE next cycle, locked_o = 0, mode_o = 001. reset_n low in SCAN -> all outputs at reset values immediately, before any clock edge.
